// File: rtl/sseg4_scan_ctrl.sv
// sseg4_scan_ctrl: digit scan and source scheduler for the four-digit display.
// The scan runs freely. The displayed value is sampled only at frame
// boundaries, so a frame never mixes digits from two different values.
// An overlay source B can take over the display for a fixed number of frames,
// after which the display returns to the live source A.
module sseg4_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,  // clocks per digit, >= 2
    parameter int HOLD_FRAMES = 250      // frames B is held per request, >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a_data,
    input  logic        a_hex_dec,
    input  logic        a_sign,
    input  logic [15:0] b_data,
    input  logic        b_hex_dec,
    input  logic        b_sign,
    input  logic        b_req,
    output logic        b_ack,
    output logic [15:0] data,
    output logic        hex_dec,
    output logic        sign,
    output logic [1:0]  digit_sel,
    output logic        src_b,
    output logic        frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

    typedef enum logic {
        SHOW_A = 1'b0,
        SHOW_B = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    digit_sel_q, digit_sel_d;
    logic          frame_tick_q;

    logic [15:0]   data_q;
    logic          hex_dec_q;
    logic          sign_q;
    logic          src_b_q;

    logic          b_req_d_q;
    logic          b_ack_q;
    state_t        state_q;
    logic [HW-1:0] hcnt_q;
    logic [15:0]   lat_data_q;
    logic          lat_hex_dec_q;
    logic          lat_sign_q;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic tc;        // prescaler terminal count
    logic fb;        // frame boundary: last clock of digit 3
    logic req_edge;  // rising edge of b_req
    logic show_b;    // the next frame should come from the B latch

    assign tc       = (pcnt_q == PCNT_LAST);
    assign fb       = tc && (digit_sel_q == 2'd3);
    assign req_edge = b_req && !b_req_d_q;
    // Uses the pre-request state/hcnt/latch, so a request landing on a
    // frame boundary only affects the frame after next.
    assign show_b   = (state_q == SHOW_B) && (hcnt_q != '0);

    // Prescaler and digit counter next-state
    always_comb begin
        pcnt_d      = pcnt_q + PW'(1);
        digit_sel_d = digit_sel_q;
        if (tc) begin
            pcnt_d      = '0;
            digit_sel_d = digit_sel_q + 2'd1;  // 3 wraps naturally to 0
        end
    end

    // Scan counters and the frame tick pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q       <= '0;
            digit_sel_q  <= 2'd0;
            frame_tick_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            digit_sel_q  <= digit_sel_d;
            frame_tick_q <= fb;
        end
    end

    // Tear-free snapshot of the displayed source, taken only at frame boundaries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= 16'h0000;
            hex_dec_q <= 1'b0;
            sign_q    <= 1'b0;
            src_b_q   <= 1'b0;
        end else if (fb) begin
            if (show_b) begin
                data_q    <= lat_data_q;
                hex_dec_q <= lat_hex_dec_q;
                sign_q    <= lat_sign_q;
                src_b_q   <= 1'b1;
            end else begin
                data_q    <= a_data;
                hex_dec_q <= a_hex_dec;
                sign_q    <= a_sign;
                src_b_q   <= 1'b0;
            end
        end
    end

    // Overlay FSM: request capture, hold countdown and acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_req_d_q     <= 1'b0;
            b_ack_q       <= 1'b0;
            state_q       <= SHOW_A;
            hcnt_q        <= '0;
            lat_data_q    <= 16'h0000;
            lat_hex_dec_q <= 1'b0;
            lat_sign_q    <= 1'b0;
        end else begin
            b_req_d_q <= b_req;
            b_ack_q   <= req_edge;
            if (req_edge) begin
                // A new request always wins, also while B is already shown.
                lat_data_q    <= b_data;
                lat_hex_dec_q <= b_hex_dec;
                lat_sign_q    <= b_sign;
                hcnt_q        <= HOLD_LOAD;
                state_q       <= SHOW_B;
            end else if (fb) begin
                case (state_q)
                    SHOW_B: begin
                        if (hcnt_q != '0) hcnt_q  <= hcnt_q - HW'(1);
                        else              state_q <= SHOW_A;
                    end
                    default: state_q <= SHOW_A;
                endcase
            end
        end
    end

    assign b_ack      = b_ack_q;
    assign data       = data_q;
    assign hex_dec    = hex_dec_q;
    assign sign       = sign_q;
    assign digit_sel  = digit_sel_q;
    assign src_b      = src_b_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// Bench for sseg4_scan_ctrl with REFRESH_DIV=4, HOLD_FRAMES=2 (16-cycle frames).
// Cycle c is the interval after c rising edges since reset release; inputs are
// driven and outputs sampled on the falling edge inside that interval.
module tb_sseg4_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a_data, b_data;
    logic        a_hex_dec, a_sign, b_hex_dec, b_sign, b_req;
    logic        b_ack, hex_dec, sign, src_b, frame_tick;
    logic [15:0] data;
    logic [1:0]  digit_sel;

    sseg4_scan_ctrl #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
        .clk(clk), .reset(reset),
        .a_data(a_data), .a_hex_dec(a_hex_dec), .a_sign(a_sign),
        .b_data(b_data), .b_hex_dec(b_hex_dec), .b_sign(b_sign),
        .b_req(b_req), .b_ack(b_ack),
        .data(data), .hex_dec(hex_dec), .sign(sign),
        .digit_sel(digit_sel), .src_b(src_b), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        hex_dec;
        logic        sign;
        logic        src_b;
        logic        b_ack;
        logic        frame_tick;
        logic [1:0]  digit_sel;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Scan pattern expected in cycle c after release; everything else idle.
    function automatic obs_t scan_exp(int c);
        obs_t e;
        e = '0;
        e.digit_sel  = 2'((c / 4) % 4);
        e.frame_tick = (c > 0) && (c % 16 == 0);
        return e;
    endfunction

    task automatic expect_push(input obs_t e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input int c);
        obs_t e, g;
        g = {data, hex_dec, sign, src_b, b_ack, frame_tick, digit_sel};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $error("FAIL %s cyc=%0d scoreboard empty, got=%h", tag, c, g);
        end else begin
            e = exp_q.pop_front();
            assert (g === e) else begin
                n_mis++;
                $error("FAIL %s cyc=%0d got=%h exp=%h (data,hd,sg,srcb,ack,ft,dsel)",
                       tag, c, g, e);
            end
        end
    endtask

    // Holds reset a few cycles, checks reset values, releases on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        b_req = 1'b0;
        repeat (2) @(negedge clk);
        expect_push(obs_t'('0));
        check("reset", -1);
        reset = 1'b0;
    endtask

    initial begin
        obs_t e;
        reset = 1'b1;
        a_data = '0; a_hex_dec = 0; a_sign = 0;
        b_data = '0; b_hex_dec = 0; b_sign = 0; b_req = 0;

        // 1: reset and scan
        a_data = 16'hA5A5; a_hex_dec = 1; a_sign = 1;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            e = scan_exp(c);
            if (c >= 16) begin e.data = 16'hA5A5; e.hex_dec = 1; e.sign = 1; end
            expect_push(e);
            check("scan", c);
            @(negedge clk);
        end

        // 2: tear-free snapshot
        a_data = 16'h1234; a_hex_dec = 0; a_sign = 0;
        do_reset();
        for (int c = 0; c < 48; c++) begin
            if (c >= 20) a_data = 16'h5678;
            e = scan_exp(c);
            if (c >= 32)      e.data = 16'h5678;
            else if (c >= 16) e.data = 16'h1234;
            expect_push(e);
            check("snapshot", c);
            @(negedge clk);
        end

        // 3: overlay request in cycle 5
        a_data = 16'h1111;
        b_data = 16'hBEEF; b_hex_dec = 1; b_sign = 1;
        do_reset();
        for (int c = 0; c < 64; c++) begin
            b_req = (c == 5);
            e = scan_exp(c);
            e.b_ack = (c == 6);
            if (c >= 16 && c <= 47) begin
                e.data = 16'hBEEF; e.hex_dec = 1; e.sign = 1; e.src_b = 1;
            end else if (c >= 48) e.data = 16'h1111;
            expect_push(e);
            check("overlay", c);
            @(negedge clk);
        end

        // 4: retrigger in cycle 40 with a new value
        b_data = 16'hBEEF;
        do_reset();
        for (int c = 0; c < 96; c++) begin
            b_req = (c == 5) || (c == 40);
            if (c == 40) b_data = 16'hCAFE;
            e = scan_exp(c);
            e.b_ack = (c == 6) || (c == 41);
            if (c >= 16 && c <= 47) begin
                e.data = 16'hBEEF; e.hex_dec = 1; e.sign = 1; e.src_b = 1;
            end else if (c >= 48 && c <= 79) begin
                e.data = 16'hCAFE; e.hex_dec = 1; e.sign = 1; e.src_b = 1;
            end else if (c >= 80) e.data = 16'h1111;
            expect_push(e);
            check("retrigger", c);
            @(negedge clk);
        end

        // 5: request edge on a frame boundary, held as a level
        b_data = 16'hBEEF;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            b_req = (c >= 15) && (c <= 60);
            e = scan_exp(c);
            e.b_ack = (c == 16);
            if (c >= 32 && c <= 63) begin
                e.data = 16'hBEEF; e.hex_dec = 1; e.sign = 1; e.src_b = 1;
            end else if (c >= 16) e.data = 16'h1111;
            expect_push(e);
            check("level_req", c);
            @(negedge clk);
        end

        // 6: reset in the middle of a hold
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            b_req = (c == 5);
            e = scan_exp(c);
            e.b_ack = (c == 6);
            if (c >= 16) begin
                e.data = 16'hBEEF; e.hex_dec = 1; e.sign = 1; e.src_b = 1;
            end
            expect_push(e);
            check("pre_abort", c);
            if (c < 35) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        expect_push(obs_t'('0));
        check("abort_async", 35);
        @(negedge clk);
        expect_push(obs_t'('0));
        check("abort_hold", 36);
        @(negedge clk);
        reset = 1'b0;
        a_data = 16'h2222;
        for (int c = 0; c < 40; c++) begin
            e = scan_exp(c);
            if (c >= 16) e.data = 16'h2222;
            expect_push(e);
            check("post_abort", c);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
